// File: rtl/int_ctl_pkg.sv
// Shared constants and state encoding for the 65C02 interrupt / wait-state sequencer.
package int_ctl_pkg;

  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctl_sync_ff.sv
// N-stage flip-flop synchronizer with asynchronous clear, used on the irq/nmi pins.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stages <= '0;
    else       stages <= {stages[N-2:0], d};
  end

  assign q = stages[N-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt arbitration (RESET > NMI > IRQ) and WAI/STP stall control for the 65C02 core.
module int_ctl
  import int_ctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  input  logic       nmi,
  input  logic       I,
  input  logic       sync,
  input  logic       wai,
  input  logic       stp,
  output logic       take_int,
  output logic [7:0] vec_lo,
  output logic       rdy
);

  logic   irq_s, nmi_s, nmi_d, nmi_edge;
  logic   rst_pend, nmi_pend;
  logic   ack;
  logic   [7:0] sel_vec;
  state_t state, next_state;

  sync_ff #(.N(SYNC_STAGES)) u_irq_sync (.clk(clk), .reset(reset), .d(irq), .q(irq_s));
  sync_ff #(.N(SYNC_STAGES)) u_nmi_sync (.clk(clk), .reset(reset), .d(nmi), .q(nmi_s));

  assign nmi_edge = nmi_s & ~nmi_d;
  assign ack      = sync & take_int & rdy;

  always_comb begin
    sel_vec = VEC_IRQ;
    if (rst_pend)      sel_vec = VEC_RESET;
    else if (nmi_pend) sel_vec = VEC_NMI;
  end

  // Pending sources, request and vector latch; vec_lo only moves on an acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_d    <= 1'b0;
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      take_int <= 1'b1;
      vec_lo   <= VEC_RESET;
    end else begin
      nmi_d    <= nmi_s;
      take_int <= rst_pend | nmi_pend | (irq_s & ~I);
      if (ack && sel_vec == VEC_RESET) rst_pend <= 1'b0;
      if (nmi_edge)                            nmi_pend <= 1'b1;
      else if (ack && sel_vec == VEC_NMI)      nmi_pend <= 1'b0;
      if (ack) vec_lo <= sel_vec;
    end
  end

  // Wake from WAIT ignores I so a masked IRQ still resumes execution.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (stp)      next_state = STOP;
        else if (wai) next_state = WAIT;
      end
      WAIT:    if (irq_s | nmi_pend) next_state = RUN;
      STOP:    next_state = STOP;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      rdy   <= 1'b1;
    end else begin
      state <= next_state;
      rdy   <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_int_ctl.sv
// Self-checking bench for int_ctl: directed scenarios plus randomized traffic against a reference model.
module tb_int_ctl;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset, irq, nmi, I, sync, wai, stp;
  logic       take_int, rdy;
  logic [7:0] vec_lo;

  int checks = 0;
  int errors = 0;

  // Reference model: pin history queues stand in for the synchronizers.
  logic  q_irq[$];
  logic  q_nmi[$];
  logic  m_nmi_prev, m_rst_pend, m_nmi_pend, m_take;
  logic  [7:0] m_vec;
  string m_mode;

  always #5 clk = ~clk;

  int_ctl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .irq(irq), .nmi(nmi), .I(I), .sync(sync),
    .wai(wai), .stp(stp), .take_int(take_int), .vec_lo(vec_lo), .rdy(rdy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic delayed(input logic q[$]);
    return (q.size() >= SYNC_STAGES) ? q[SYNC_STAGES-1] : 1'b0;
  endfunction

  function automatic void modelReset();
    q_irq.delete();
    q_nmi.delete();
    m_nmi_prev = 1'b0;
    m_rst_pend = 1'b1;
    m_nmi_pend = 1'b0;
    m_take     = 1'b1;
    m_vec      = 8'hFC;
    m_mode     = "RUN";
  endfunction

  function automatic void modelStep();
    logic irq_now, nmi_now, rising, acked;
    logic [7:0] pick;
    irq_now = delayed(q_irq);
    nmi_now = delayed(q_nmi);
    rising  = nmi_now && !m_nmi_prev;
    acked   = sync && m_take && (m_mode == "RUN");
    pick    = m_rst_pend ? 8'hFC : (m_nmi_pend ? 8'hFA : 8'hFE);
    m_take  = m_rst_pend || m_nmi_pend || (irq_now && !I);
    if (acked) m_vec = pick;
    if (m_mode == "RUN") begin
      if (stp)      m_mode = "STOP";
      else if (wai) m_mode = "WAIT";
    end else if (m_mode == "WAIT" && (irq_now || m_nmi_pend)) begin
      m_mode = "RUN";
    end
    if (acked && pick == 8'hFC) m_rst_pend = 1'b0;
    m_nmi_pend = rising || (m_nmi_pend && !(acked && pick == 8'hFA));
    m_nmi_prev = nmi_now;
    q_irq.push_front(irq);
    q_nmi.push_front(nmi);
    if (q_irq.size() > SYNC_STAGES) void'(q_irq.pop_back());
    if (q_nmi.size() > SYNC_STAGES) void'(q_nmi.pop_back());
  endfunction

  task automatic compareModel(input string tag);
    checkOutput({tag, ".take_int"}, {7'd0, take_int}, {7'd0, m_take});
    checkOutput({tag, ".vec_lo"}, vec_lo, m_vec);
    checkOutput({tag, ".rdy"}, {7'd0, rdy}, {7'd0, (m_mode == "RUN")});
  endtask

  task automatic applyStimulus(input logic i_irq, i_nmi, i_I, i_sync, i_wai, i_stp);
    irq = i_irq; nmi = i_nmi; I = i_I; sync = i_sync; wai = i_wai; stp = i_stp;
    @(posedge clk);
    modelStep();
    #1;
    compareModel("model");
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    modelReset();
    #1;
    compareModel("reset");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset followed by the mandatory RESET acknowledge, leaving a quiet core.
  task automatic cleanStart();
    doReset(1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic r_irq, r_nmi, r_I;
    reset = 1'b0; irq = 0; nmi = 0; I = 0; sync = 0; wai = 0; stp = 0;
    modelReset();
    @(negedge clk);

    // Reset with both pins high: RESET wins, then NMI, then IRQ.
    irq = 1; nmi = 1;
    doReset(3);
    checkOutput("rst.take", {7'd0, take_int}, 8'd1);
    checkOutput("rst.vec", vec_lo, 8'hFC);
    checkOutput("rst.rdy", {7'd0, rdy}, 8'd1);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("rst.ack_vec", vec_lo, 8'hFC);
    repeat (5) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("rst.nmi_vec", vec_lo, 8'hFA);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("rst.irq_vec", vec_lo, 8'hFE);

    // IRQ masking.
    cleanStart();
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, (i % 4 == 3), 0, 0);
    checkOutput("mask.take", {7'd0, take_int}, 8'd0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("unmask.take", {7'd0, take_int}, 8'd1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("unmask.vec", vec_lo, 8'hFE);

    // NMI edge held high, then a second edge landing in the acknowledge cycle.
    cleanStart();
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("nmi.vec", vec_lo, 8'hFA);
    repeat (4) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("nmi.once", {7'd0, take_int}, 8'd0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("nmi2.first", vec_lo, 8'hFA);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("nmi2.still", {7'd0, take_int}, 8'd1);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("nmi2.second", vec_lo, 8'hFA);

    // Priority and no vector hijack.
    cleanStart();
    repeat (5) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("prio.vec", vec_lo, 8'hFA);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("hijack.irq", vec_lo, 8'hFE);
    repeat (5) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("hijack.hold", vec_lo, 8'hFE);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("hijack.next", vec_lo, 8'hFA);

    // WAI with masked IRQ wake-up.
    cleanStart();
    applyStimulus(0, 0, 1, 0, 1, 0);
    checkOutput("wai.rdy", {7'd0, rdy}, 8'd0);
    for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("wai.wake", {7'd0, rdy}, {7'd0, (i == SYNC_STAGES + 1)});
    end
    checkOutput("wai.take", {7'd0, take_int}, 8'd0);

    // STP ignores pins until reset.
    cleanStart();
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(i[1], i[0], 0, 1, 0, 0);
    checkOutput("stp.rdy", {7'd0, rdy}, 8'd0);
    #2;
    doReset(1);
    checkOutput("stp.rst_rdy", {7'd0, rdy}, 8'd1);
    checkOutput("stp.rst_vec", vec_lo, 8'hFC);

    // Randomized traffic.
    r_irq = 0; r_nmi = 0; r_I = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) doReset($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) r_irq = ~r_irq;
      if ($urandom_range(0, 7) == 0) r_nmi = ~r_nmi;
      if ($urandom_range(0, 15) == 0) r_I = ~r_I;
      applyStimulus(r_irq, r_nmi, r_I, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 59) == 0), ($urandom_range(0, 249) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctl.md
# int_ctl

Interrupt and wait-state sequencer for the 65C02 core. It synchronizes the external `irq` and `nmi` pins, latches NMI edges, tracks the post-reset vector fetch, and arbitrates by priority RESET > NMI > IRQ. It feeds the microcode controller a single `take_int` request, sampled at instruction boundaries, together with a stable vector low byte. It also owns the WAI/STP stall state that gates `rdy` to the core.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on the `irq`/`nmi` pins; legal values 2..3.
- `clk` input 1: core clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; this is the decided reset for the block.
- `irq` input 1: level-sensitive interrupt request, active high, asynchronous to `clk`.
- `nmi` input 1: non-maskable interrupt, active high, asynchronous; only a rising edge counts.
- `I` input 1: processor interrupt-disable flag.
- `sync` input 1: high in the cycle where the controller decodes the next opcode.
- `wai` input 1: one-cycle pulse from microcode when a WAI instruction executes.
- `stp` input 1: one-cycle pulse from microcode when an STP instruction executes.
- `take_int` output 1: registered; an interrupt sequence must replace the next opcode.
- `vec_lo` output 8: vector low byte, which is 8'hFC (reset), 8'hFA (NMI) or 8'hFE (IRQ).
- `rdy` output 1: registered; low stalls the core.

## Operation
- **Synchronizers.**
  - `irq_s` and `nmi_s` are produced by `SYNC_STAGES` flops each, reset to 0.
  - `nmi_d` is a one-cycle delay of `nmi_s`.
  - `nmi_edge = nmi_s & ~nmi_d`.
- **Pending sources.**
  - `rst_pend`: set to 1 by reset; cleared on an acknowledge whose latched vector is RESET.
  - `nmi_pend`: set by `nmi_edge`; cleared on an acknowledge whose latched vector is NMI. If `nmi_edge` and that clear occur in the same cycle, `nmi_pend` stays 1 (set wins).
  - IRQ is not latched. It is requested only while `irq_s & ~I`.
- **Request.** `take_int` is registered from `rst_pend | nmi_pend | (irq_s & ~I)`.
- **Acknowledge.** An acknowledge occurs in a cycle with `sync & take_int & rdy`. In that cycle, the highest-priority pending source is latched into `vec_lo`. `vec_lo` then holds until the next acknowledge, so there is no vector hijack mid-sequence. An NMI arriving during an IRQ sequence is serviced at the next `sync`.
- **State machine** (states RUN, WAIT, STOP; reset state RUN):
  - RUN → WAIT on `wai`.
  - RUN → STOP on `stp`.
  - If `wai` and `stp` are asserted together, `stp` wins.
  - WAIT → RUN when `irq_s | nmi_pend`. `I` is ignored for wake-up; if `I`=1, execution resumes without taking the IRQ.
  - STOP is left only by `reset`.
- **`rdy`.** `rdy` is 1 in RUN and 0 in WAIT and STOP. While `rdy`=0, no acknowledge occurs, but `nmi_pend` still latches edges.
- **Reset values** (asserting `reset` at any time, including mid-sequence or in STOP):
  - `take_int`=1, `vec_lo`=8'hFC, `rdy`=1.
  - `rst_pend`=1, `nmi_pend`=0.
  - Synchronizers cleared.
  - state=RUN.
  - The first acknowledge after reset always selects RESET, even if NMI or IRQ is pending.

## Timing
- `irq` rising at edge 0:
  - `irq_s`=1 after `SYNC_STAGES` edges.
  - `take_int`=1 one edge later (3 cycles for default).
- `nmi` rising at edge 0: `nmi_pend` and then `take_int` follow at `SYNC_STAGES`+1 and `SYNC_STAGES`+2 edges.
- `irq` falling or `I` set: `take_int` drops `SYNC_STAGES`+1 cycles later for an `irq` fall, or 1 cycle later for `I`. A request dropped before `sync` is never taken (6502 level semantics).
- `vec_lo` updates on the edge ending the acknowledge cycle. It is valid for the vector fetch, which occurs 5 or more cycles later.
- `take_int` deasserts on the edge after an acknowledge clears the last pending source. A still-asserted IRQ keeps it high.
- `wai` pulse at edge n: `rdy`=0 from edge n+1.
- Wake condition true at edge m: `rdy`=1 from edge m+1.

## Structure
- A shared package holds:
  - `VEC_RESET`=8'hFC, `VEC_NMI`=8'hFA, `VEC_IRQ`=8'hFE;
  - the state encoding type (RUN/WAIT/STOP).
- One sub-module: `sync_ff`, a parameterized N-stage synchronizer with asynchronous reset, instantiated for `irq` and `nmi`.
- Edge detect, pending logic, priority and the FSM stay in `int_ctl`.

## Test plan
- **Reset sequence.** Hold `reset` 3 cycles with `irq`=`nmi`=1, then release and pulse `sync` → `take_int`=1, `vec_lo`=FC, `rdy`=1. After the acknowledge, the next acknowledge gives `vec_lo`=FA.
- **IRQ masking.** `I`=1, `irq`=1 for 20 cycles with periodic `sync` → `take_int` stays 0. Clear `I` → `take_int`=1 one cycle later; acknowledge gives `vec_lo`=FE.
- **NMI edge.** Pulse `nmi` for 3 cycles and hold high afterwards → exactly one acknowledge with `vec_lo`=FA, then `take_int`=0. A second rising edge during the acknowledge cycle → a second FA acknowledge.
- **Priority / no hijack.** `irq` and `nmi` rise together → acknowledge gives FA. An `nmi` rising during a subsequent IRQ sequence leaves `vec_lo`=FE until the next `sync`.
- **WAI.** `wai` pulse → `rdy`=0 next cycle. `irq`=1 with `I`=1 → `rdy`=1 after `SYNC_STAGES`+1 cycles and `take_int`=0.
- **STP.** `stp` pulse, then `nmi`/`irq` toggling → `rdy` stays 0. Asserting `reset` mid-STOP → `rdy`=1 immediately and `vec_lo`=FC.
